// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state codes and the conditional-negate helpers for the RV32M sequencer.
package muldiv_pkg;

  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  localparam logic [4:0] LAST_STEP = 5'd31;

  // Two's-complement negate when n is set; used for operand magnitudes and result fix-up.
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
    return n ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] neg_if64(input logic [63:0] v, input logic n);
    return n ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide: start in IDLE, 32 CALC steps, done pulse in FIN (33 cycles; 1 for div special cases).
// No queueing: start is ignored while busy; flush or rst return to IDLE without a done pulse.
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic        neg_q, neg_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] rem_q, rem_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;

  logic        in_div;
  logic        a_signed;
  logic        b_signed;
  logic        res_neg;
  logic        div_zero;
  logic        div_ovf;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] special_res;

  always_comb begin
    in_div   = funct3[2];
    a_signed = (funct3 == MDU_MULH) || (funct3 == MDU_MULHSU) ||
               (funct3 == MDU_DIV)  || (funct3 == MDU_REM);
    b_signed = (funct3 == MDU_MULH) || (funct3 == MDU_DIV) || (funct3 == MDU_REM);
    a_mag    = neg_if(rs1, a_signed & rs1[31]);
    b_mag    = neg_if(rs2, b_signed & rs2[31]);
    div_zero = in_div && (rs2 == 32'd0);
    div_ovf  = ((funct3 == MDU_DIV) || (funct3 == MDU_REM)) &&
               (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
    case (funct3)
      MDU_MULH, MDU_DIV:  res_neg = rs1[31] ^ rs2[31];
      MDU_MULHSU, MDU_REM: res_neg = rs1[31];
      default:            res_neg = 1'b0;
    endcase
    // Quotient ops and remainder ops differ only in which special value they return.
    if ((funct3 == MDU_DIV) || (funct3 == MDU_DIVU)) begin
      special_res = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
    end else begin
      special_res = div_zero ? rs1 : 32'd0;
    end
  end

  logic [32:0] mul_sum;
  logic [63:0] mul_nxt;
  logic [32:0] div_shl;
  logic [32:0] div_diff;
  logic [31:0] quo_nxt;
  logic [31:0] rem_nxt;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] fin_res;

  // acc_q holds {partial product, multiplier} for multiply and {0, dividend/quotient} for divide.
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, dvs_q} : 33'd0);
    mul_nxt  = {mul_sum, acc_q[31:1]};
    div_shl  = {rem_q, acc_q[31]};
    div_diff = div_shl - {1'b0, dvs_q};
    quo_nxt  = {acc_q[30:0], ~div_diff[32]};
    rem_nxt  = div_diff[32] ? div_shl[31:0] : div_diff[31:0];
    prod_fix = neg_if64(mul_nxt, neg_q);
    quo_fix  = neg_if(quo_nxt, neg_q);
    rem_fix  = neg_if(rem_nxt, neg_q);
    case (op_q)
      MDU_MUL:                          fin_res = prod_fix[31:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU:  fin_res = prod_fix[63:32];
      MDU_DIV, MDU_DIVU:                fin_res = quo_fix;
      default:                          fin_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d  = funct3;
          neg_d = res_neg;
          cnt_d = 5'd0;
          if (div_zero || div_ovf) begin
            result_d = special_res;
            done_d   = 1'b1;
            state_d  = ST_FIN;
          end else begin
            dvs_d   = in_div ? b_mag : a_mag;
            acc_d   = in_div ? {32'd0, a_mag} : {32'd0, b_mag};
            rem_d   = 32'd0;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q + 5'd1;
        if (op_q[2]) begin
          acc_d = {32'd0, quo_nxt};
          rem_d = rem_nxt;
        end else begin
          acc_d = mul_nxt;
        end
        // Result is registered on the last step so it is valid alongside done in FIN.
        if (cnt_q == LAST_STEP) begin
          result_d = fin_res;
          done_d   = 1'b1;
          state_d  = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (flush) begin
      state_d  = ST_IDLE;
      cnt_d    = 5'd0;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 5'd0;
      op_q     <= MDU_MUL;
      neg_q    <= 1'b0;
      acc_q    <= 64'd0;
      dvs_q    <= 32'd0;
      rem_q    <= 32'd0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed vector table, hand-written flush/reset/retrigger sequences, random ops vs. arithmetic model.
module tb_muldiv_seq;

  localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3;
  localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  muldiv_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural result from plain integer arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    sa = a;
    sb = b;
    case (f)
      F_MUL:    begin p = longint'(sa) * longint'(sb); return p[31:0]; end
      F_MULH:   begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      F_MULHSU: begin p = longint'(sa) * longint'({32'd0, b}); return p[63:32]; end
      F_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      F_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      F_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      F_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 32'd0) return 1;
    if ((f == F_DIV || f == F_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issues one op, scrambles operands afterwards, optionally pokes start at cycle poke_c
  // or in the done cycle, and returns the done-cycle result, latency and busy/idle violations.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int poke_c, input logic fin_poke,
                        output logic [31:0] res, output int lat,
                        output int bad_busy, output int bad_after);
    int c;
    @(negedge clk);
    start = 1'b1; funct3 = f; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    start = 1'b0; funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
    c = 1; lat = 0; res = '0; bad_busy = 0;
    while (c <= 40 && lat == 0) begin
      if (c == poke_c) begin
        start = 1'b1; funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
      end else begin
        start = 1'b0;
      end
      if (!busy) bad_busy++;
      if (done) begin
        lat = c;
        res = result;
      end else begin
        @(posedge clk); #1;
        c++;
      end
    end
    if (lat != 0 && fin_poke) begin
      start = 1'b1; funct3 = F_MUL; rs1 = 32'd3; rs2 = 32'd5;
    end
    @(posedge clk); #1;
    start = 1'b0;
    bad_after = (busy || done) ? 1 : 0;
  endtask

  logic [31:0] res;
  logic [31:0] prev;
  int lat, bad_busy, bad_after, pulses;

  initial begin
    rst = 1'b1; start = 1'b0; funct3 = 3'd0; rs1 = 32'd0; rs2 = 32'd0; flush = 1'b0;
    vecs[0]  = '{F_MUL,    32'd7,           32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{F_MULH,   32'h8000_0000,   32'h8000_0000, 32'h4000_0000, 33};
    vecs[2]  = '{F_MULHU,  32'hFFFF_FFFF,   32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[3]  = '{F_MULHSU, 32'hFFFF_FFFF,   32'd2,         32'hFFFF_FFFF, 33};
    vecs[4]  = '{F_DIV,    32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFD, 33};
    vecs[5]  = '{F_REM,    32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFF, 33};
    vecs[6]  = '{F_DIVU,   32'd100,         32'd7,         32'd14,        33};
    vecs[7]  = '{F_REMU,   32'd100,         32'd7,         32'd2,         33};
    vecs[8]  = '{F_DIVU,   32'h1234,        32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{F_REM,    32'h1234,        32'd0,         32'h1234,      1};
    vecs[10] = '{F_DIV,    32'h8000_0000,   32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{F_REM,    32'h8000_0000,   32'hFFFF_FFFF, 32'd0,         1};
    vecs[12] = '{F_DIVU,   32'hFFFF_FFFF,   32'd1,         32'hFFFF_FFFF, 33};
    vecs[13] = '{F_DIV,    32'h8000_0000,   32'd2,         32'hC000_0000, 33};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_busy",   {31'd0, busy}, 32'd0);
    check("reset_done",   {31'd0, done}, 32'd0);
    check("reset_result", result,        32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, 0, 1'b0, res, lat, bad_busy, bad_after);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_busy_held", i), 32'(bad_busy), 32'd0);
      check($sformatf("vec%0d_idle_after", i), 32'(bad_after), 32'd0);
    end

    // start while busy is ignored
    run_op(F_MUL, 32'd7, 32'hFFFF_FFFD, 5, 1'b0, res, lat, bad_busy, bad_after);
    check("busy_start_result",  res,       32'hFFFF_FFEB);
    check("busy_start_latency", 32'(lat),  32'd33);

    // start in the done cycle is ignored, start one cycle later is accepted
    run_op(F_DIVU, 32'd100, 32'd7, 0, 1'b1, res, lat, bad_busy, bad_after);
    check("fin_start_result",  res,             32'd14);
    check("fin_start_ignored", 32'(bad_after),  32'd0);
    run_op(F_REMU, 32'd100, 32'd7, 0, 1'b0, res, lat, bad_busy, bad_after);
    check("retrigger_result",  res,      32'd2);
    check("retrigger_latency", 32'(lat), 32'd33);

    // flush at cycle 10 of a MUL
    prev = result;
    @(negedge clk);
    start = 1'b1; funct3 = F_MUL; rs1 = 32'd9; rs2 = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check("flush_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_idle",   {31'd0, busy}, 32'd0);
    check("flush_done",   {31'd0, done}, 32'd0);
    check("flush_result", result,        prev);
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("flush_no_done", 32'(pulses), 32'd0);
    check("flush_hold",    result,      prev);

    // flush coincident with start stays idle
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = F_DIVU; rs1 = 32'd50; rs2 = 32'd0;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_idle", {31'd0, busy}, 32'd0);
    check("flush_start_done", {31'd0, done}, 32'd0);

    // reset mid-DIV
    @(negedge clk);
    start = 1'b1; funct3 = F_DIV; rs1 = 32'd1000; rs2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_done",   {31'd0, done}, 32'd0);
    check("rst_result", result,        32'd0);

    // randomized ops against the arithmetic model
    for (int n = 0; n < 60; n++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
        3: b = -32'($urandom_range(1, 20));
        default: ;
      endcase
      run_op(f, a, b, 0, 1'b0, res, lat, bad_busy, bad_after);
      check($sformatf("rnd%0d_f%0d_%h_%h_result", n, f, a, b), res, ref_result(f, a, b));
      check($sformatf("rnd%0d_latency", n), 32'(lat), 32'(ref_latency(f, a, b)));
      check($sformatf("rnd%0d_busy_held", n), 32'(bad_busy), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
